// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, owner ids and default limits for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_MAX_CPU_BURST = 4;
endpackage

// File: rtl/arb_grant_sel.sv
// arb_grant_sel: CPU-priority grant with forced DMA grant once the CPU streak saturates
module arb_grant_sel #(
  parameter int MAX_CPU_BURST = 4,
  parameter int SW = 3
) (
  input  logic          i_cpu_req,
  input  logic          i_dma_req,
  input  logic [SW-1:0] i_streak,
  output logic          o_grant_cpu,
  output logic          o_grant_dma
);
  assign o_grant_dma = i_dma_req && (i_streak == SW'(MAX_CPU_BURST) || !i_cpu_req);
  assign o_grant_cpu = i_cpu_req && !o_grant_dma;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU and DMA with a req/ack handshake,
// bounded DMA starvation and a sticky memory-timeout abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_CPU_BURST = DEF_MAX_CPU_BURST,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err_timeout
);
  localparam int SW = $clog2(MAX_CPU_BURST + 1);
  state_t        r_state, w_next;
  logic          r_owner, r_we, r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_cpu_rdata, r_dma_rdata, w_cap;
  logic [SW-1:0] r_streak;
  logic [7:0]    r_timer;
  logic          w_grant_cpu, w_grant_dma, w_grant, w_timeout, w_done;
  arb_grant_sel #(.MAX_CPU_BURST(MAX_CPU_BURST), .SW(SW)) u_sel (
    .i_cpu_req  (cpu_req),
    .i_dma_req  (dma_req),
    .i_streak   (r_streak),
    .o_grant_cpu(w_grant_cpu),
    .o_grant_dma(w_grant_dma)
  );
  assign w_grant   = w_grant_cpu || w_grant_dma;
  assign w_timeout = r_timer == 8'(TIMEOUT - 1);
  assign w_done    = mem_ack || w_timeout;
  // writes and aborted accesses return zero data
  assign w_cap     = (mem_ack && !r_we) ? mem_rdata : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE  ? (w_grant ? ISSUE : IDLE) :
             r_state == ISSUE ? (w_done ? RESP : ISSUE) : IDLE;
  end
  always_comb begin
    mem_req = r_state == ISSUE;
    busy    = r_state != IDLE;
    cpu_ack = r_state == RESP && r_owner == OWN_CPU;
    dma_ack = r_state == RESP && r_owner == OWN_DMA;
  end
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign cpu_rdata   = r_cpu_rdata;
  assign dma_rdata   = r_dma_rdata;
  assign err_timeout = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_streak    <= '0;
      r_timer     <= '0;
      r_err       <= 1'b0;
    end else if (r_state == IDLE) begin
      r_timer <= '0;
      if (w_grant) begin
        r_owner <= w_grant_dma ? OWN_DMA : OWN_CPU;
        r_we    <= w_grant_dma ? dma_we : cpu_we;
        r_addr  <= w_grant_dma ? dma_addr : cpu_addr;
        r_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
      end
      r_streak <= (w_grant_dma || !dma_req) ? '0 :
                  (w_grant_cpu && r_streak != SW'(MAX_CPU_BURST)) ? r_streak + SW'(1) : r_streak;
    end else if (r_state == ISSUE) begin
      r_timer <= r_timer + 8'd1;
      if (w_done) begin
        if (r_owner == OWN_DMA) r_dma_rdata <= w_cap;
        else                    r_cpu_rdata <= w_cap;
        r_err <= r_err || !mem_ack;
      end
    end
  end
endmodule
